// File: rtl/tdm_frame_scheduler_if.sv
// Bundles the TDM pins, CPU handshake and status outputs of tdm_frame_scheduler.
// The master drives the pins and ack; the slave is the scheduler.
interface tdm_frame_scheduler_if;
  logic       enable;
  logic       f0;
  logic       c4;
  logic [4:0] slot_sel;
  logic       cpu_ack;
  logic       locked;
  logic [4:0] slot_idx;
  logic       slot_strobe;
  logic       bit_strobe;
  logic       bank_sel;
  logic       cpu_int;
  logic       overrun;
  logic       sync_err;

  modport master (
    output enable, f0, c4, slot_sel, cpu_ack,
    input  locked, slot_idx, slot_strobe, bit_strobe, bank_sel, cpu_int, overrun, sync_err
  );

  modport slave (
    input  enable, f0, c4, slot_sel, cpu_ack,
    output locked, slot_idx, slot_strobe, bit_strobe, bank_sel, cpu_int, overrun, sync_err
  );
endinterface

// File: rtl/tdm_frame_scheduler.sv
// TDM frame scheduler: locks to f0/c4, issues slot/bit strobes and ping-pong block interrupts.
// Define FRAME_LOSS_DET_EN to drop lock on a missing f0 and pulse sync_err.
module tdm_frame_scheduler #(
  parameter int C4_PER_FRAME = 512,
  parameter int NUM_FRAMES   = 16
) (
  input  logic                 clk50,
  input  logic                 reset,
  tdm_frame_scheduler_if.slave bus
);

  localparam logic [9:0] LAST_C4    = 10'(C4_PER_FRAME - 1);
  localparam logic [4:0] LAST_FRAME = 5'(NUM_FRAMES - 1);

  typedef enum logic {HUNT, RUN} state_e;

  state_e     state_q, state_d;
  logic [2:0] c4_sync_q;
  logic [1:0] f0_sync_q;
  logic       f0_prev_q, f0_prev_d;
  logic [9:0] c4_cnt_q, c4_cnt_d;
  logic [4:0] frame_cnt_q, frame_cnt_d;
  logic [4:0] slot_q, slot_d;
  logic       bank_q, bank_d;
  logic       cpu_int_q, cpu_int_d;
  logic       overrun_q, overrun_d;
  logic       slot_strobe_q, slot_strobe_d;
  logic       bit_strobe_q, bit_strobe_d;
  logic       sync_err_q, sync_err_d;

  logic c4_rise, f0_s, frame_start;
  logic frame_end, block_done, f0_hold;

  assign c4_rise     = c4_sync_q[1] & ~c4_sync_q[2];
  assign f0_s        = f0_sync_q[1];
  // Only the first c4 edge of a low f0 marks a frame, so long pulses count once.
  assign frame_start = c4_rise & ~f0_s & f0_prev_q;

  always_comb begin
    state_d       = state_q;
    c4_cnt_d      = c4_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    slot_d        = slot_q;
    bank_d        = bank_q;
    f0_prev_d     = c4_rise ? f0_s : f0_prev_q;
    slot_strobe_d = 1'b0;
    bit_strobe_d  = 1'b0;
    sync_err_d    = 1'b0;
    frame_end     = 1'b0;
    block_done    = 1'b0;
    f0_hold       = 1'b0;

    case (state_q)
      HUNT: begin
        if (bus.enable && frame_start) begin
          state_d     = RUN;
          c4_cnt_d    = '0;
          frame_cnt_d = '0;
          slot_d      = bus.slot_sel;
        end
      end
      RUN: begin
        if (!bus.enable) begin
          state_d = HUNT;
        end else if (c4_rise) begin
          if (frame_start) begin
            c4_cnt_d  = '0;
            frame_end = 1'b1;
`ifdef FRAME_LOSS_DET_EN
            if (c4_cnt_q != LAST_C4) sync_err_d = 1'b1;
`endif
          end else if (!f0_s) begin
            c4_cnt_d = '0;
            f0_hold  = 1'b1;
          end else if (c4_cnt_q == LAST_C4) begin
`ifdef FRAME_LOSS_DET_EN
            sync_err_d  = 1'b1;
            state_d     = HUNT;
            frame_cnt_d = '0;
`else
            c4_cnt_d  = '0;
            frame_end = 1'b1;
`endif
          end else begin
            c4_cnt_d = c4_cnt_q + 10'd1;
          end
        end
      end
      default: state_d = HUNT;
    endcase

    if (frame_end) begin
      slot_d = bus.slot_sel;
      if (frame_cnt_q == LAST_FRAME) begin
        frame_cnt_d = '0;
        bank_d      = ~bank_q;
        block_done  = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + 5'd1;
      end
    end

    if (state_d == HUNT) c4_cnt_d = '0;

    // Strobes only for counting edges that keep us in RUN; the lock edge and f0 holds are excluded.
    if (state_q == RUN && state_d == RUN && c4_rise && !f0_hold) begin
      slot_strobe_d = (c4_cnt_d == {1'b0, slot_d, 4'h0});
      bit_strobe_d  = (c4_cnt_d[8:4] == slot_d) && c4_cnt_d[0];
    end
  end

  // A new block beats a simultaneous ack so the interrupt is never lost.
  assign cpu_int_d = block_done | (cpu_int_q & ~bus.cpu_ack);
  assign overrun_d = (block_done & cpu_int_q & ~bus.cpu_ack) | (overrun_q & ~bus.cpu_ack);

  always_ff @(posedge clk50) begin
    if (reset) begin
      state_q       <= HUNT;
      c4_sync_q     <= '0;
      f0_sync_q     <= '1;
      f0_prev_q     <= 1'b1;
      c4_cnt_q      <= '0;
      frame_cnt_q   <= '0;
      slot_q        <= '0;
      bank_q        <= 1'b0;
      cpu_int_q     <= 1'b0;
      overrun_q     <= 1'b0;
      slot_strobe_q <= 1'b0;
      bit_strobe_q  <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      c4_sync_q     <= {c4_sync_q[1:0], bus.c4};
      f0_sync_q     <= {f0_sync_q[0], bus.f0};
      f0_prev_q     <= f0_prev_d;
      c4_cnt_q      <= c4_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      slot_q        <= slot_d;
      bank_q        <= bank_d;
      cpu_int_q     <= cpu_int_d;
      overrun_q     <= overrun_d;
      slot_strobe_q <= slot_strobe_d;
      bit_strobe_q  <= bit_strobe_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign bus.locked      = (state_q == RUN);
  assign bus.slot_idx    = c4_cnt_q[8:4];
  assign bus.slot_strobe = slot_strobe_q;
  assign bus.bit_strobe  = bit_strobe_q;
  assign bus.bank_sel    = bank_q;
  assign bus.cpu_int     = cpu_int_q;
  assign bus.overrun     = overrun_q;
  assign bus.sync_err    = sync_err_q;

endmodule
